// File: rtl/fetch_stage_pkg.sv
// Shared rv32 fetch definitions: reset/NOP defaults, FSM state encoding and
// the buffered instruction entry layout.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int unsigned ENTRY_W           = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// Two-entry FIFO holding fetched {pc, instr} pairs; flush wins over push/pop.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    // NOTE: entry storage is deliberately not reset; count_q alone says which slots are live.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester, redirect
// handling with stale-response kill, and a two-entry buffer towards decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  last_pc_q;
    logic [1:0]   count;
    logic         accept;
    logic         push;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign imem_req_o  = !rst_i && (state_q == ST_IDLE) && (count <= 2'd1);
    assign imem_addr_o = fetch_pc_q;
    assign accept      = imem_req_o && imem_ready_i;

    // NOTE: every always_comb output gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_pc_d   = fetch_pc_q;
        end
        if (redirect_i) begin
            fetch_pc_d = align_word(redirect_pc_i);
        end
        case (state_q)
            ST_IDLE: if (accept) state_d = redirect_i ? ST_KILL : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = ST_IDLE;
                    push    = !redirect_i;
                end else if (redirect_i) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: if (imem_rvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            if (valid_o) last_pc_q <= head.pc;
        end
    end

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};
    assign pop        = valid_o && ready_i && !redirect_i;

    fetch_buffer #(
        .WIDTH (ENTRY_W)
    ) u_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (count)
    );

    assign valid_o   = (count != 2'd0);
    assign instr_o   = valid_o ? head.instr : NOP_INSTR;
    assign pc_o      = valid_o ? head.pc : last_pc_q;
    assign pc_next_o = pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, back-pressure, redirects,
// PC wrap and asynchronous reset, against hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        imem_ready_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        ready_i = 1'b1;

    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, instr_o, pc_o, pc_next_o;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc_next;

    int checks   = 0;
    int failures = 0;

    logic        mem_auto = 1'b1;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_next_o     (pc_next_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem_req_o    (w_req),
        .imem_addr_o   (w_addr),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (w_valid),
        .ready_i       (ready_i),
        .instr_o       (w_instr),
        .pc_o          (w_pc),
        .pc_next_o     (w_pc_next)
    );

    // A push into a full buffer must never happen.
    always @(negedge clk) begin
        if (!rst_i && dut.u_buffer.push_i && dut.u_buffer.count_o == 2'd2) begin
            failures++;
            $display("FAIL push_when_full got count=%0d required <2", dut.u_buffer.count_o);
        end
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0050_0093 + (a << 8);
    endfunction

    task automatic mem_sample();
        pend      = mem_auto && imem_req_o && imem_ready_i;
        pend_addr = imem_addr_o;
    endtask

    // Advance one cycle; the memory model answers 1 cycle after acceptance.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (mem_auto) begin
            imem_rvalid_i = pend;
            imem_rdata_i  = pend ? instr_of(pend_addr) : 32'h0;
        end
        mem_sample();
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        pend          = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        mem_sample();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk);
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b required=0", imem_req_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", valid_o); end
        checks++; if (instr_o !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr got=%h required=00000013", instr_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h required=00000000", imem_addr_o); end
        checks++; if (w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_addr_wrap got=%h required=fffffffc", w_addr); end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL rst_first_req got=%b required=1", imem_req_o); end
    endtask

    task automatic test_basic();
        mem_auto = 1'b1; ready_i = 1'b1;
        do_reset();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL basic_c1_req got=%b/%h required=1/00000000", imem_req_o, imem_addr_o); end
        step();
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin failures++; $display("FAIL basic_c2 got valid=%b req=%b required 0/0", valid_o, imem_req_o); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || pc_next_o !== 32'h4 || instr_o !== 32'h0050_0093) begin
            failures++; $display("FAIL basic_c3_head got v=%b pc=%h nx=%h in=%h required 1/00000000/00000004/00500093", valid_o, pc_o, pc_next_o, instr_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin failures++; $display("FAIL basic_c3_req got=%b/%h required=1/00000004", imem_req_o, imem_addr_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_c4_valid got=%b required=0", valid_o); end
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h0050_0493) begin
            failures++; $display("FAIL basic_c5_head got v=%b pc=%h in=%h required 1/00000004/00500493", valid_o, pc_o, instr_o); end
    endtask

    task automatic test_backpressure();
        mem_auto = 1'b1; ready_i = 1'b0;
        do_reset();
        repeat (4) step();
        checks++; if (dut.u_buffer.count_o !== 2'd2 || imem_req_o !== 1'b0) begin
            failures++; $display("FAIL bp_full got count=%0d req=%b required 2/0", dut.u_buffer.count_o, imem_req_o); end
        checks++; if (pc_o !== 32'h0 || instr_o !== 32'h0050_0093) begin failures++; $display("FAIL bp_head0 got pc=%h in=%h required 00000000/00500093", pc_o, instr_o); end
        step();
        checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'h0) begin failures++; $display("FAIL bp_hold got req=%b pc=%h required 0/00000000", imem_req_o, pc_o); end
        ready_i = 1'b1;
        step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h0050_0493) begin
            failures++; $display("FAIL bp_head1 got v=%b pc=%h in=%h required 1/00000004/00500493", valid_o, pc_o, instr_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin failures++; $display("FAIL bp_resume got=%b/%h required=1/00000008", imem_req_o, imem_addr_o); end
        step();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b required=0", valid_o); end
    endtask

    task automatic test_redirect_wait();
        mem_auto = 1'b0; ready_i = 1'b1;
        do_reset();
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL rdw_kill got=%b/%h required=0/00000100", imem_req_o, imem_addr_o); end
        step();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin failures++; $display("FAIL rdw_dropped got v=%b in=%h required 0/00000013", valid_o, instr_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL rdw_next got=%b/%h required=1/00000100", imem_req_o, imem_addr_o); end
        mem_auto = 1'b1;
    endtask

    task automatic test_redirect_rvalid();
        mem_auto = 1'b1; ready_i = 1'b0;
        do_reset();
        repeat (3) step();
        checks++; if (valid_o !== 1'b1 || imem_rvalid_i !== 1'b1) begin failures++; $display("FAIL rdr_setup got v=%b rv=%b required 1/1", valid_o, imem_rvalid_i); end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || dut.u_buffer.count_o !== 2'd0) begin failures++; $display("FAIL rdr_flush got v=%b count=%0d required 0/0", valid_o, dut.u_buffer.count_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin failures++; $display("FAIL rdr_next got=%b/%h required=1/00000200", imem_req_o, imem_addr_o); end
        repeat (2) step();
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h0052_0093) begin
            failures++; $display("FAIL rdr_target got v=%b pc=%h in=%h required 1/00000200/00520093", valid_o, pc_o, instr_o); end
        ready_i = 1'b1;
    endtask

    task automatic test_wrap();
        mem_auto = 1'b1; ready_i = 1'b1;
        do_reset();
        checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first got=%b/%h required=1/fffffffc", w_req, w_addr); end
        repeat (2) step();
        checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc_next !== 32'h0) begin
            failures++; $display("FAIL wrap_head got v=%b pc=%h nx=%h required 1/fffffffc/00000000", w_valid, w_pc, w_pc_next); end
        checks++; if (w_addr !== 32'h0) begin failures++; $display("FAIL wrap_second_req got=%h required=00000000", w_addr); end
    endtask

    task automatic test_async_reset();
        mem_auto = 1'b1; ready_i = 1'b0;
        do_reset();
        repeat (2) step();
        mem_auto = 1'b0;
        step();
        checks++; if (valid_o !== 1'b1 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h8) begin
            failures++; $display("FAIL ar_setup got v=%b req=%b addr=%h required 1/0/00000008", valid_o, imem_req_o, imem_addr_o); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b0 || instr_o !== 32'h0000_0013 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL ar_immediate got v=%b req=%b in=%h addr=%h required 0/0/00000013/00000000", valid_o, imem_req_o, instr_o, imem_addr_o); end
        @(negedge clk);
        rst_i = 1'b0; imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL ar_stray_rvalid got v=%b req=%b addr=%h required 0/1/00000000", valid_o, imem_req_o, imem_addr_o); end
        imem_ready_i = 1'b1; ready_i = 1'b1; mem_auto = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instr_o value while the buffer is empty.
REQ-003 clk_i  input  1  SHALL be the single clock, rising edge.
REQ-004 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_req_o  output  1  SHALL be the instruction-memory request valid.
REQ-006 imem_addr_o  output  32  SHALL be the request address, word-aligned.
REQ-007 imem_ready_i  input  1  SHALL mean the request is accepted this cycle when high together with imem_req_o.
REQ-008 imem_rvalid_i  input  1  SHALL mean response data is valid; it arrives at least 1 cycle after acceptance.
REQ-009 imem_rdata_i  input  32  SHALL carry the response instruction word.
REQ-010 redirect_i  input  1  SHALL be a branch/jump redirect pulse.
REQ-011 redirect_pc_i  input  32  SHALL be the redirect target.
REQ-012 valid_o  output  1  SHALL mean instr_o/pc_o/pc_next_o hold a live instruction for decode.
REQ-013 ready_i  input  1  SHALL mean decode consumes the head entry this cycle when valid_o is high.
REQ-014 instr_o  output  32  SHALL be the head instruction.
REQ-015 pc_o  output  32  SHALL be the head instruction address.
REQ-016 pc_next_o  output  32  SHALL be pc_o + 4, modulo 2^32.

Function
REQ-017 fetch_pc register SHALL drive imem_addr_o; it SHALL advance by 4 on each accepted request, wrapping at 2^32.
REQ-018 The FSM SHALL have states IDLE (none outstanding), WAIT (one live request outstanding) and KILL (one stale request outstanding); at most one request SHALL be outstanding.
REQ-019 imem_req_o SHALL be high only in IDLE with buffer count <= 1; memory samples the address only on acceptance, and an unaccepted request MAY change address or drop.
REQ-020 Transitions: IDLE->WAIT on acceptance without redirect; IDLE->KILL on acceptance with redirect; WAIT->IDLE on rvalid; WAIT->KILL on redirect without rvalid; WAIT->IDLE on redirect with rvalid, discarding the response; KILL->IDLE on rvalid, discarding the response.
REQ-021 Two-entry FIFO of {pc, instr}: push on rvalid in WAIT without redirect; pop on valid_o && ready_i; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 A push at count 2 SHALL be impossible by construction; a bench assertion SHALL flag it.
REQ-023 Push-to-output latency: an entry written on an rvalid edge SHALL appear at the head (valid_o high if previously empty) in the next cycle; there is no combinational bypass.
REQ-024 Redirect SHALL flush the FIFO (count 0, valid_o low next cycle), load fetch_pc with {redirect_pc_i[31:2],2'b00}, and take priority over push, pop and PC increment.
REQ-025 A redirect in KILL SHALL reload fetch_pc and stay in KILL.
REQ-026 With count 0, instr_o SHALL be NOP_INSTR; pc_o and pc_next_o SHALL show the last head values (don't-care to decode).
REQ-027 Throughput SHALL be one instruction per 2 cycles with a zero-wait memory returning rvalid 1 cycle after acceptance.

Reset
REQ-028 While rst_i is high: fetch_pc = RESET_PC, state = IDLE, count = 0, valid_o = 0, imem_req_o = 0, instr_o = NOP_INSTR.
REQ-029 imem_req_o SHALL first assert in the first cycle after rst_i deasserts.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; a response arriving after reset release with no request issued SHALL be ignored (state IDLE).

Structure
REQ-031 RESET_PC default, NOP_INSTR and the FSM state encodings SHALL live in the shared rv32 definitions include.
REQ-032 The FIFO SHALL be a sub-module named fetch_buffer (depth 2, width 64, push/pop/flush, count output).

Verification
REQ-033 Reset release, ready_i=1, imem_ready_i=1, 1-cycle memory returning 0x00500093 -> request at 0x0 in cycle 1; valid_o, pc_o=0x0, pc_next_o=0x4 and instr_o=0x00500093 in cycle 3; next request at 0x4.
REQ-034 ready_i=0 with continuous responses -> exactly 2 entries buffered (pc 0x0, 0x4), imem_req_o held low; after ready_i rises, entries pop in order.
REQ-035 Redirect to 0x103 while in WAIT, stale rvalid 2 cycles later -> stale data dropped, valid_o low, next request at 0x100.
REQ-036 Redirect in the same cycle as rvalid, with count 1 -> FIFO emptied, the response not pushed, state IDLE, next address = target.
REQ-037 RESET_PC=0xFFFFFFFC -> second request address 0x00000000, and pc_next_o = 0x0 for the first instruction.
REQ-038 rst_i asserted while in WAIT -> outputs take their reset values immediately (asynchronously); a later rvalid is ignored.
